// File: rtl/sadd_sat_pipe_if.sv
// Stream bundle for sadd_sat_pipe: operand/op request channel and result channel.
// The slave modport is the arithmetic unit's view; master is the producer/consumer view.
interface sadd_sat_pipe_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         ovf;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, ovf
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, ovf
    );
endinterface

// File: rtl/sadd_sat_pipe.sv
// sadd_sat_pipe: signed add/sub/accumulate with overflow detection, optional
// saturation (SAT) and a sticky overflow flag, behind a one-entry output register.
// Optional feature macro: SADD_OVF_CNT_EN adds the ovf_count port and a
// saturating overflow event counter.
module sadd_sat_pipe #(
    parameter int W     = 8,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sadd_sat_pipe_if.slave bus,
    input  logic           clr_ovf,
    output logic           ovf_sticky
`ifdef SADD_OVF_CNT_EN
    ,
    output logic [CNT_W-1:0] ovf_count
`endif
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;

    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

    // Reject nonsensical parameterisations at elaboration time
    if (W < 2 || CNT_W < 1) begin : g_bad_params
        $error("sadd_sat_pipe: W must be >= 2 and CNT_W >= 1");
    end

    logic [W-1:0] res_q;
    logic         ovf_q;
    logic         out_valid_q;
    logic [W-1:0] acc_q;
    logic         sticky_q;

    logic         accept;
    logic [W-1:0] opx;
    logic [W-1:0] opy;
    logic         is_sub;
    logic         is_acc;
    logic         is_clr;
    logic [W:0]   full;
    logic [W-1:0] raw;
    logic         ovf_d;
    logic [W-1:0] res_d;

    // One-entry output register: free when empty or being drained this cycle
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.ovf       = ovf_q;
    assign ovf_sticky    = sticky_q;

    // Select operands, compute in W+1 bits, detect overflow and apply wrap/saturate
    always_comb begin
        opx    = bus.a;
        opy    = bus.b;
        is_sub = 1'b0;
        is_acc = 1'b0;
        is_clr = 1'b0;
        case (bus.op)
            OP_ADD: begin
                opx = bus.a;
                opy = bus.b;
            end
            OP_SUB: begin
                is_sub = 1'b1;
            end
            OP_ACC: begin
                is_acc = 1'b1;
                opx    = acc_q;
                opy    = bus.a;
            end
            default: begin
                // CLR: 0 + 0 yields res=0 and ovf=0 through the normal path
                is_clr = 1'b1;
                opx    = '0;
                opy    = '0;
            end
        endcase

        if (is_sub) begin
            full = {opx[W-1], opx} - {opy[W-1], opy};
        end else begin
            full = {opx[W-1], opx} + {opy[W-1], opy};
        end
        raw = full[W-1:0];

        // Overflow is judged against the sign of the first operand
        if (is_sub) begin
            ovf_d = (opx[W-1] != opy[W-1]) && (raw[W-1] != opx[W-1]);
        end else begin
            ovf_d = (opx[W-1] == opy[W-1]) && (raw[W-1] != opx[W-1]);
        end

        res_d = raw;
        if (SAT != 0 && ovf_d) begin
            // A negative first operand can only overflow downwards, and vice versa
            res_d = opx[W-1] ? NEG_MIN : POS_MAX;
        end
    end

    // Output register: load on accept, empty when drained without a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accumulator follows the post-wrap/saturation result; ADD/SUB leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept && is_acc) begin
            acc_q <= res_d;
        end else if (accept && is_clr) begin
            acc_q <= '0;
        end
    end

    // Sticky overflow: a new overflow wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (accept && ovf_d) begin
            sticky_q <= 1'b1;
        end else if (clr_ovf) begin
            sticky_q <= 1'b0;
        end
    end

`ifdef SADD_OVF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    assign ovf_count = cnt_q;

    // Saturating overflow event counter; clear plus overflow restarts at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && ovf_d) begin
            if (clr_ovf) begin
                cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (clr_ovf) begin
            cnt_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_sadd_sat_pipe.sv
// Self-checking bench for sadd_sat_pipe: a wrapping (SAT=0) and a saturating
// (SAT=1) instance share one stimulus stream; an integer reference model feeds
// a scoreboard queue that is compared as results are produced.
module tb_sadd_sat_pipe;

    localparam int W     = 8;
    localparam int CNT_W = 2;
    localparam int MAXV  = (1 << (W - 1)) - 1;
    localparam int MINV  = -(1 << (W - 1));

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_ready;
    logic         clr_ovf;
    logic         sticky0;
    logic         sticky1;

    sadd_sat_pipe_if #(.W(W)) bus0 ();
    sadd_sat_pipe_if #(.W(W)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.op        = op;
    assign bus0.a         = a;
    assign bus0.b         = b;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.op        = op;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.out_ready = out_ready;

`ifdef SADD_OVF_CNT_EN
    logic [CNT_W-1:0] cnt0_o;
    logic [CNT_W-1:0] cnt1_o;
    int               cnt_m0;
    int               cnt_m1;
`endif

    sadd_sat_pipe #(.W(W), .SAT(0), .CNT_W(CNT_W)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus0.slave),
        .clr_ovf    (clr_ovf),
        .ovf_sticky (sticky0)
`ifdef SADD_OVF_CNT_EN
        ,
        .ovf_count  (cnt0_o)
`endif
    );

    sadd_sat_pipe #(.W(W), .SAT(1), .CNT_W(CNT_W)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus1.slave),
        .clr_ovf    (clr_ovf),
        .ovf_sticky (sticky1)
`ifdef SADD_OVF_CNT_EN
        ,
        .ovf_count  (cnt1_o)
`endif
    );

    typedef struct {
        logic [W-1:0] r0;
        logic         o0;
        logic [W-1:0] r1;
        logic         o1;
    } exp_t;

    exp_t sb[$];

    int   checks = 0;
    int   errors = 0;
    logic m_ov;
    int   acc_m0;
    int   acc_m1;
    logic st0;
    logic st1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Integer reference: exact sum, then wrap or clamp into W bits
    function automatic void model(input logic [1:0] o, input int x, input int y,
                                  input int accv, input bit sat,
                                  output logic [W-1:0] r, output logic ov,
                                  output int acc_out);
        int full;
        int w;
        case (o)
            ADD:     full = x + y;
            SUB:     full = x - y;
            ACC:     full = accv + x;
            default: full = 0;
        endcase
        ov = (full > MAXV) || (full < MINV);
        w  = full;
        if (ov) begin
            if (sat)              w = (full > MAXV) ? MAXV : MINV;
            else if (full > MAXV) w = full - (1 << W);
            else                  w = full + (1 << W);
        end
        r = w[W-1:0];
        if (o == ACC)      acc_out = w;
        else if (o == CLR) acc_out = 0;
        else               acc_out = accv;
    endfunction

    // One clock of stimulus: check registered outputs, drive, check in_ready,
    // update model and scoreboard, then advance to just after the next edge.
    task automatic step(input logic v, input logic [1:0] o, input int av, input int bv,
                        input logic ordy, input logic clr);
        exp_t e;
        logic acc_now;
        int   na0;
        int   na1;

        check("out_valid0", {31'd0, bus0.out_valid}, {31'd0, m_ov});
        check("out_valid1", {31'd0, bus1.out_valid}, {31'd0, m_ov});
        if (m_ov) begin
            check("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb[0];
                check("res0", {24'd0, bus0.res}, {24'd0, e.r0});
                check("ovf0", {31'd0, bus0.ovf}, {31'd0, e.o0});
                check("res1", {24'd0, bus1.res}, {24'd0, e.r1});
                check("ovf1", {31'd0, bus1.ovf}, {31'd0, e.o1});
            end
        end
        check("sticky0", {31'd0, sticky0}, {31'd0, st0});
        check("sticky1", {31'd0, sticky1}, {31'd0, st1});
`ifdef SADD_OVF_CNT_EN
        check("ovf_count0", 32'(cnt0_o), 32'(cnt_m0));
        check("ovf_count1", 32'(cnt1_o), 32'(cnt_m1));
`endif

        in_valid  = v;
        op        = o;
        a         = av[W-1:0];
        b         = bv[W-1:0];
        out_ready = ordy;
        clr_ovf   = clr;
        #1;

        check("in_ready0", {31'd0, bus0.in_ready}, {31'd0, !m_ov || ordy});
        check("in_ready1", {31'd0, bus1.in_ready}, {31'd0, !m_ov || ordy});
        acc_now = v && (!m_ov || ordy);

        if (m_ov && ordy && sb.size() > 0) void'(sb.pop_front());

        if (acc_now) begin
            model(o, av, bv, acc_m0, 1'b0, e.r0, e.o0, na0);
            model(o, av, bv, acc_m1, 1'b1, e.r1, e.o1, na1);
            acc_m0 = na0;
            acc_m1 = na1;
            sb.push_back(e);
            $display("txn op=%0d a=%0d b=%0d clr=%0b -> wrap res=%0h ovf=%0b | sat res=%0h ovf=%0b",
                     o, av, bv, clr, e.r0, e.o0, e.r1, e.o1);
        end

        st0 = (acc_now && e.o0) ? 1'b1 : (clr ? 1'b0 : st0);
        st1 = (acc_now && e.o1) ? 1'b1 : (clr ? 1'b0 : st1);
`ifdef SADD_OVF_CNT_EN
        if (acc_now && e.o0)  cnt_m0 = clr ? 1 : ((cnt_m0 < (1 << CNT_W) - 1) ? cnt_m0 + 1 : cnt_m0);
        else if (clr)         cnt_m0 = 0;
        if (acc_now && e.o1)  cnt_m1 = clr ? 1 : ((cnt_m1 < (1 << CNT_W) - 1) ? cnt_m1 + 1 : cnt_m1);
        else if (clr)         cnt_m1 = 0;
`endif

        @(posedge clk);
        #1;
        m_ov = acc_now ? 1'b1 : (ordy ? 1'b0 : m_ov);
    endtask

    task automatic model_reset();
        m_ov   = 1'b0;
        acc_m0 = 0;
        acc_m1 = 0;
        st0    = 1'b0;
        st1    = 1'b0;
        sb.delete();
`ifdef SADD_OVF_CNT_EN
        cnt_m0 = 0;
        cnt_m1 = 0;
`endif
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid0"}, {31'd0, bus0.out_valid}, 32'd0);
        check({tag, "_out_valid1"}, {31'd0, bus1.out_valid}, 32'd0);
        check({tag, "_res0"},       {24'd0, bus0.res},       32'd0);
        check({tag, "_res1"},       {24'd0, bus1.res},       32'd0);
        check({tag, "_ovf0"},       {31'd0, bus0.ovf},       32'd0);
        check({tag, "_sticky0"},    {31'd0, sticky0},        32'd0);
        check({tag, "_sticky1"},    {31'd0, sticky1},        32'd0);
`ifdef SADD_OVF_CNT_EN
        check({tag, "_count0"},     32'(cnt0_o),             32'd0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = ADD;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset
        step(0, ADD, 0, 0, 1, 0);

        // ADD 127+1: wrap gives 0x80, saturate gives 0x7F, both flag overflow
        step(1, ADD, 127, 1, 1, 0);
        step(0, ADD, 0, 0, 1, 0);
        // Clear sticky with nothing accepted
        step(0, ADD, 0, 0, 1, 1);
        step(0, ADD, 0, 0, 1, 0);

        // SUB -128-1 overflows negative; SUB 5-(-3) = 8 clean
        step(1, SUB, -128, 1, 1, 0);
        step(1, SUB, 5, -3, 1, 0);
        step(0, ADD, 0, 0, 1, 0);

        // Accumulate 100 twice, then clear; follow-up ACC proves acc is zero
        step(1, ACC, 100, 0, 1, 0);
        step(1, ACC, 100, 0, 1, 0);
        step(1, CLR, 0, 0, 1, 0);
        step(1, ACC, 7, 0, 1, 0);
        step(0, ADD, 0, 0, 1, 0);

        // Backpressure: result 3 held for three cycles, pending ADD refused
        step(1, ADD, 1, 2, 1, 0);
        step(1, ADD, 10, 20, 0, 0);
        step(1, ADD, 10, 20, 0, 0);
        step(1, ADD, 10, 20, 0, 0);
        step(1, ADD, 10, 20, 1, 0);
        step(0, ADD, 0, 0, 1, 0);

        // Back-to-back stream, clear coinciding with an overflowing op
        step(1, ADD, 3, 4, 1, 0);
        step(1, ADD, -100, -100, 1, 1);
        step(1, ADD, 50, 60, 1, 0);
        step(1, ADD, -1, -1, 1, 0);
        step(0, ADD, 0, 0, 1, 0);
        step(0, ADD, 0, 0, 1, 0);

        // Five overflows in a row drive the event counter to its ceiling
        for (int i = 0; i < 5; i++) step(1, ADD, 100, 100, 1, 0);
        step(0, ADD, 0, 0, 1, 0);

        // Reset while a result sits in the output register
        step(1, ACC, 50, 0, 1, 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_zero_outputs("midreset");
        model_reset();
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        step(0, ADD, 0, 0, 1, 0);
        step(0, ADD, 0, 0, 1, 0);
        step(1, ACC, 5, 0, 1, 0);
        step(0, ADD, 0, 0, 1, 0);
        step(0, ADD, 0, 0, 1, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
